// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, FP32 field layout, integer
// saturation limits and operand classification helpers.
package fpu_pkg;

   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } rm_e;

   localparam int unsigned FP32_BIAS   = 127;
   localparam int unsigned FP32_EXP_W  = 8;
   localparam int unsigned FP32_FRAC_W = 23;

   localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
   localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
   localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;

   function automatic logic is_nan(input logic [31:0] f);
      return (f[FP32_FRAC_W +: FP32_EXP_W] == '1) && (f[FP32_FRAC_W-1:0] != '0);
   endfunction

   function automatic logic is_inf(input logic [31:0] f);
      return (f[FP32_FRAC_W +: FP32_EXP_W] == '1) && (f[FP32_FRAC_W-1:0] == '0);
   endfunction

endpackage

// File: rtl/float_to_int_converter_if.sv
// Issue/result handshake bundle of the FP32-to-integer converter.
interface float_to_int_converter_if;
   logic        valid_in;
   logic        ready_out;
   logic [31:0] a;
   logic [2:0]  rm;
   logic        signed_in;
   logic        valid_out;
   logic        ready_in;
   logic [31:0] int_out;
   logic        NV;
   logic        NX;

   modport master (
      output valid_in, a, rm, signed_in, ready_in,
      input  ready_out, valid_out, int_out, NV, NX
   );

   modport slave (
      input  valid_in, a, rm, signed_in, ready_in,
      output ready_out, valid_out, int_out, NV, NX
   );
endinterface

// File: rtl/float_to_int_converter_shift.sv
// 32-bit logarithmic right shifter returning the shifted value, the first
// dropped bit (guard) and the OR of every bit dropped below it (sticky).
module shift_right_sticky_32 (
   input  logic [31:0] din,
   input  logic [4:0]  amt,
   output logic [31:0] dout,
   output logic        guard,
   output logic        sticky
);

   logic [63:0] stage;

   // Five binary-weighted stages; the low 32 bits catch everything shifted out.
   always_comb begin
      stage = {din, 32'b0};
      for (int unsigned i = 0; i < 5; i++) begin
         if (amt[i]) begin
            stage = stage >> (1 << i);
         end
      end
      dout   = stage[63:32];
      guard  = stage[31];
      sticky = |stage[30:0];
   end

endmodule

// File: rtl/float_to_int_converter.sv
// Two-stage FP32 -> int32/uint32 converter (FCVT.W.S / FCVT.WU.S).
// S1 decodes and aligns the significand; S2 rounds, range-checks,
// negates/saturates and raises NV/NX.
module float_to_int_converter
   import fpu_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   float_to_int_converter_if.slave io
);

   typedef struct packed {
      logic        sign;
      logic        sgn_mode;
      logic [2:0]  rm;
      logic        nan;
      logic        ovf;
      logic [31:0] ipart;
      logic        g;
      logic        s;
   } s1_t;

   s1_t         s1_q, s1_d, s1_new;
   logic        s1_valid_q, s1_valid_d;
   logic        s2_valid_q, s2_valid_d;
   logic [31:0] int_q, int_d;
   logic        nv_q, nv_d;
   logic        nx_q, nx_d;

   logic [7:0]  exp_f;
   logic [22:0] frac_f;
   logic [23:0] mant;
   logic [4:0]  sh_amt;
   logic [31:0] sh_out;
   logic        sh_g, sh_s;

   logic        s1_adv, accept, in_xfer;
   logic        inc, invalid, nx_calc;
   logic [32:0] mag_r;
   logic [31:0] res;

   shift_right_sticky_32 u_shift (
      .din    ({mant, 8'b0}),
      .amt    (sh_amt),
      .dout   (sh_out),
      .guard  (sh_g),
      .sticky (sh_s)
   );

   // S1 decode: classify the operand and align the significand to the integer point.
   always_comb begin
      exp_f  = io.a[30:23];
      frac_f = io.a[22:0];
      mant   = {exp_f != '0, frac_f};
      sh_amt = 5'(8'(FP32_BIAS + 31) - exp_f);
      s1_new          = '0;
      s1_new.sign     = io.a[31];
      s1_new.sgn_mode = io.signed_in;
      s1_new.rm       = io.rm;
      s1_new.nan      = is_nan(io.a);
      s1_new.ovf      = exp_f >= 8'(FP32_BIAS + 32);
      if (exp_f >= 8'(FP32_BIAS)) begin
         s1_new.ipart = sh_out;
         s1_new.g     = sh_g;
         s1_new.s     = sh_s;
      end else begin
         // Below one: exponent -1 puts the hidden bit in the guard position.
         s1_new.ipart = '0;
         s1_new.g     = exp_f == 8'(FP32_BIAS - 1);
         s1_new.s     = s1_new.g ? |frac_f : |mant;
      end
   end

   // Handshake and S1 next state: S1 advances whenever S2 is empty or draining.
   always_comb begin
      s1_adv     = !s2_valid_q || io.ready_in;
      accept     = !reset && (!s1_valid_q || s1_adv);
      in_xfer    = io.valid_in && accept;
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      if (in_xfer) begin
         s1_valid_d = 1'b1;
         s1_d       = s1_new;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   // S2 compute: rounding increment, range check, negation or saturation, flags.
   always_comb begin
      case (s1_q.rm)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = s1_q.sign && (s1_q.g || s1_q.s);
         RM_RUP:  inc = !s1_q.sign && (s1_q.g || s1_q.s);
         RM_RMM:  inc = s1_q.g;
         default: inc = s1_q.g && (s1_q.s || s1_q.ipart[0]);
      endcase
      mag_r = {1'b0, s1_q.ipart} + 33'(inc);

      if (s1_q.ovf) begin
         invalid = 1'b1;
      end else if (s1_q.sgn_mode) begin
         invalid = s1_q.sign ? (mag_r > 33'h0_8000_0000) : (mag_r >= 33'h0_8000_0000);
      end else begin
         invalid = s1_q.sign ? (mag_r != '0) : mag_r[32];
      end

      if (invalid) begin
         if (s1_q.nan || !s1_q.sign) begin
            res = s1_q.sgn_mode ? INT32_MAX : UINT32_MAX;
         end else begin
            res = s1_q.sgn_mode ? INT32_MIN : '0;
         end
      end else begin
         res = s1_q.sign ? (~mag_r[31:0] + 32'd1) : mag_r[31:0];
      end
      nx_calc = (s1_q.g || s1_q.s) && !invalid;
   end

   // S2 next state: load from S1 on advance, otherwise hold the presented result.
   always_comb begin
      s2_valid_d = s2_valid_q;
      int_d      = int_q;
      nv_d       = nv_q;
      nx_d       = nx_q;
      if (s1_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            int_d = res;
            nv_d  = invalid;
            nx_d  = nx_calc;
         end
      end
   end

   // Pipeline registers with synchronous reset discarding in-flight operands.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         int_q      <= '0;
         nv_q       <= 1'b0;
         nx_q       <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_q       <= s1_d;
         s2_valid_q <= s2_valid_d;
         int_q      <= int_d;
         nv_q       <= nv_d;
         nx_q       <= nx_d;
      end
   end

   assign io.ready_out = accept;
   assign io.valid_out = s2_valid_q;
   assign io.int_out   = int_q;
   assign io.NV        = nv_q;
   assign io.NX        = nx_q;

endmodule

// File: tb/tb_float_to_int_converter.sv
// Self-checking bench for float_to_int_converter: directed vectors, a
// stalled stream, reset with a full pipe, and randomized traffic against a
// real-arithmetic reference model.
module tb_float_to_int_converter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   float_to_int_converter_if io();

   float_to_int_converter dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [2:0]  rm;
      logic        sg;
      logic [31:0] res;
      logic        nv;
      logic        nx;
   } vec_t;

   localparam int NDIR = 19;
   vec_t dir [NDIR];

   int unsigned tests_run = 0;
   int unsigned tests_failed = 0;
   logic [33:0] exp_q[$];
   int          inflight = 0;
   bit          stall_prev = 1'b0;
   logic [33:0] held = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, want, $time);
      end
   endtask

   function automatic real pow2(input int k);
      real r;
      r = 1.0;
      if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
      else for (int i = 0; i < -k; i++) r = r / 2.0;
      return r;
   endfunction

   // Reference: exact value as a real, rounded by fraction, then range-checked.
   function automatic logic [33:0] model(input logic [31:0] x, input logic [2:0] rmv, input bit sg);
      bit     neg, inexact, up;
      int     ex, fr;
      real    mag, t, fpart;
      longint r, v, lo, hi;
      logic [63:0] vb;
      neg = x[31];
      ex  = int'(x[30:23]);
      fr  = int'(x[22:0]);
      lo  = sg ? -(64'sd1 <<< 31) : 64'sd0;
      hi  = sg ? (64'sd1 <<< 31) - 1 : (64'sd1 <<< 32) - 1;
      if (ex == 255) begin
         if (fr != 0 || !neg) return {(sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF), 2'b10};
         return {(sg ? 32'h8000_0000 : 32'h0), 2'b10};
      end
      if (ex == 0) mag = real'(fr) * pow2(-149);
      else mag = real'(fr + (1 << 23)) * pow2(ex - 150);
      if (mag >= pow2(33)) begin
         if (neg) return {(sg ? 32'h8000_0000 : 32'h0), 2'b10};
         return {(sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF), 2'b10};
      end
      t       = $floor(mag);
      fpart   = mag - t;
      r       = longint'(t);
      inexact = fpart != 0.0;
      case (rmv)
         3'd1:    up = 1'b0;
         3'd2:    up = neg && inexact;
         3'd3:    up = !neg && inexact;
         3'd4:    up = fpart >= 0.5;
         default: up = (fpart > 0.5) || (fpart == 0.5 && (r % 2) == 1);
      endcase
      r = r + longint'(up);
      v = neg ? -r : r;
      if (v < lo) return {(sg ? 32'h8000_0000 : 32'h0), 2'b10};
      if (v > hi) return {(sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF), 2'b10};
      vb = v;
      return {vb[31:0], 1'b0, inexact};
   endfunction

   function automatic logic [31:0] rand_a();
      logic [7:0]  ex;
      logic [22:0] fr;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel < 6) ex = 8'($urandom_range(110, 162));
      else if (sel < 8) ex = 8'($urandom_range(0, 255));
      else ex = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      fr = 23'($urandom);
      if ($urandom_range(0, 3) == 0) fr[15:0] = '0;
      if (sel == 9 && $urandom_range(0, 1) != 0) fr = '0;
      return {1'($urandom), ex, fr};
   endfunction

   // One cycle: drive at negedge, then observe handshakes before the next posedge.
   task automatic step(input bit v, input logic [31:0] av, input logic [2:0] rmv, input bit sg,
                       input bit rdy, input logic [33:0] expv, output bit took, output bit gave);
      logic [33:0] e;
      @(negedge clk);
      io.valid_in  = v;
      io.a         = av;
      io.rm        = rmv;
      io.signed_in = sg;
      io.ready_in  = rdy;
      #1;
      if (stall_prev) begin
         check("hold_valid", io.valid_out, 1);
         check("hold_data", {io.int_out, io.NV, io.NX}, held);
      end
      check("ready_out", io.ready_out, (inflight < 2) || rdy);
      took = v && io.ready_out;
      gave = io.valid_out && rdy;
      if (io.valid_out) check("nv_nx_exclusive", io.NV && io.NX, 0);
      if (gave) begin
         check("out_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("int_out", io.int_out, e[33:2]);
            check("flags_nv_nx", {io.NV, io.NX}, e[1:0]);
         end
      end
      if (took) exp_q.push_back(expv);
      inflight   = inflight + int'(took) - int'(gave);
      stall_prev = io.valid_out && !rdy;
      held       = {io.int_out, io.NV, io.NX};
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset       = 1'b1;
      io.valid_in = 1'b0;
      io.ready_in = 1'b0;
      #1 check("ready_out_in_reset", io.ready_out, 0);
      repeat (n) @(negedge clk);
      #1;
      check("valid_out_after_reset", io.valid_out, 0);
      check("int_out_after_reset", io.int_out, 0);
      check("nv_after_reset", io.NV, 0);
      check("nx_after_reset", io.NX, 0);
      reset = 1'b0;
      #1 check("ready_out_after_reset", io.ready_out, 1);
      exp_q.delete();
      inflight   = 0;
      stall_prev = 1'b0;
   endtask

   task automatic drain();
      bit tk, gv;
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         step(0, '0, '0, 0, 1, '0, tk, gv);
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      bit          tk, gv, v, rdy, rsg, have;
      int          lat, issued;
      logic [31:0] ra;
      logic [2:0]  rrm;

      dir[0]  = {32'h4020_0000, 3'd0, 1'b1, 32'd2,         2'b01};
      dir[1]  = {32'h4020_0000, 3'd4, 1'b1, 32'd3,         2'b01};
      dir[2]  = {32'h4020_0000, 3'd3, 1'b1, 32'd3,         2'b01};
      dir[3]  = {32'h4020_0000, 3'd1, 1'b1, 32'd2,         2'b01};
      dir[4]  = {32'hCF00_0000, 3'd1, 1'b1, 32'h8000_0000, 2'b00};
      dir[5]  = {32'h4F00_0000, 3'd0, 1'b1, 32'h7FFF_FFFF, 2'b10};
      dir[6]  = {32'hBE99_999A, 3'd1, 1'b0, 32'h0,         2'b01};
      dir[7]  = {32'hBE99_999A, 3'd2, 1'b0, 32'h0,         2'b10};
      dir[8]  = {32'hBE99_999A, 3'd2, 1'b1, 32'hFFFF_FFFF, 2'b01};
      dir[9]  = {32'h7FC0_0000, 3'd0, 1'b1, 32'h7FFF_FFFF, 2'b10};
      dir[10] = {32'h7FC0_0000, 3'd0, 1'b0, 32'hFFFF_FFFF, 2'b10};
      dir[11] = {32'h8000_0000, 3'd0, 1'b1, 32'h0,         2'b00};
      dir[12] = {32'h0000_0001, 3'd0, 1'b1, 32'h0,         2'b01};
      dir[13] = {32'h4F80_0000, 3'd0, 1'b0, 32'hFFFF_FFFF, 2'b10};
      dir[14] = {32'h4F7F_FFFF, 3'd0, 1'b0, 32'hFFFF_FF00, 2'b00};
      dir[15] = {32'h4060_0000, 3'd0, 1'b1, 32'd4,         2'b01};
      dir[16] = {32'h4020_0000, 3'd5, 1'b1, 32'd2,         2'b01};
      dir[17] = {32'hFF80_0000, 3'd0, 1'b1, 32'h8000_0000, 2'b10};
      dir[18] = {32'hCF00_0001, 3'd1, 1'b1, 32'h8000_0000, 2'b10};

      io.valid_in  = 1'b0;
      io.a         = '0;
      io.rm        = '0;
      io.signed_in = 1'b0;
      io.ready_in  = 1'b0;
      do_reset(2);

      // Single operand: result must appear two cycles after its in-transfer.
      step(1, 32'h4020_0000, 3'd0, 1, 1, {32'd2, 2'b01}, tk, gv);
      check("first_issue", tk, 1);
      lat = 0;
      gv  = 1'b0;
      while (!gv && lat < 10) begin
         step(0, '0, '0, 0, 1, '0, tk, gv);
         lat++;
      end
      check("latency", lat, 2);

      // Directed vectors back to back.
      for (int i = 0; i < NDIR; i++) begin
         tk = 1'b0;
         for (int g = 0; g < 20 && !tk; g++)
            step(1, dir[i].a, dir[i].rm, dir[i].sg, 1, {dir[i].res, dir[i].nv, dir[i].nx}, tk, gv);
         check("dir_issue", tk, 1);
      end
      drain();

      // Eight-operand stream with ready_in low for three cycles mid-stream.
      issued = 0;
      have   = 1'b0;
      for (int c = 0; c < 60 && issued < 8; c++) begin
         if (!have) begin
            ra = rand_a(); rrm = 3'($urandom_range(0, 7)); rsg = 1'($urandom); have = 1'b1;
         end
         rdy = !(c >= 3 && c < 6);
         step(1, ra, rrm, rsg, rdy, model(ra, rrm, rsg), tk, gv);
         if (tk) begin issued++; have = 1'b0; end
      end
      check("stream_issued", issued, 8);
      drain();

      // Fill both stages, then reset for one cycle.
      step(1, 32'h4120_0000, 3'd0, 1, 0, model(32'h4120_0000, 3'd0, 1), tk, gv);
      check("fill_s1", tk, 1);
      step(1, 32'hC120_0000, 3'd0, 1, 0, model(32'hC120_0000, 3'd0, 1), tk, gv);
      check("fill_s2", tk, 1);
      step(1, 32'h4000_0000, 3'd0, 1, 0, '0, tk, gv);
      check("full_blocks_issue", tk, 0);
      check("full_valid_out", io.valid_out, 1);
      do_reset(1);

      // Randomized traffic with random valid and ready.
      issued = 0;
      have   = 1'b0;
      for (int c = 0; c < 6000 && issued < 400; c++) begin
         if (!have) begin
            ra = rand_a(); rrm = 3'($urandom_range(0, 7)); rsg = 1'($urandom); have = 1'b1;
         end
         v   = $urandom_range(0, 3) != 0;
         rdy = $urandom_range(0, 9) < 7;
         step(v, ra, rrm, rsg, rdy, model(ra, rrm, rsg), tk, gv);
         if (tk) begin issued++; have = 1'b0; end
      end
      check("random_issued", issued, 400);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/float_to_int_converter.md
# float_to_int_converter

Pipelined FP32-to-integer converter for the FPU, implementing the RISC-V FCVT.W.S / FCVT.WU.S semantics. It is the inverse path of the integer-to-float normalizer. Where that path counts leading zeros and shifts left to normalise, this block shifts the significand right by the exponent-derived amount, then rounds, negates and saturates. It sits beside the other FPU execution units behind the same valid/ready issue handshake.

## Interface
- No parameters; the format is fixed at FP32 in, 32-bit integer out.
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  operand valid
- ready_out  out  1  converter can accept an operand this cycle
- a  in  32  IEEE-754 single-precision operand
- rm  in  3  static rounding mode; dynamic mode is already resolved upstream
- signed_in  in  1  1 = FCVT.W.S (int32), 0 = FCVT.WU.S (uint32)
- valid_out  out  1  result valid
- ready_in  in  1  downstream accepts the result
- int_out  out  32  converted integer
- NV  out  1  invalid-operation flag
- NX  out  1  inexact flag

## Operation
- Transfers:
  - In-transfer occurs when valid_in && ready_out.
  - Out-transfer occurs when valid_out && ready_in.
- Decode:
  - e = exp − 127.
  - Significand m = {exp != 0, frac}; subnormals carry a hidden bit of 0.
  - Zero and subnormal inputs give a magnitude of 0, with NX set if the input is nonzero.
- Magnitude:
  - If 0 <= e <= 31: the 32-bit value {m, 8'b0} is shifted right by (31 − e).
  - This produces a 32-bit integer part, a guard bit G, and a sticky bit S, where S is the OR of all bits shifted out below G.
  - If e < 0: integer part = 0, G = (e == −1), S = all remaining bits of m.
  - If e >= 32: overflow; the rounding logic is bypassed.
- Rounding: an increment is computed on the 33-bit magnitude.
  - RNE (000): G && (S || lsb).
  - RTZ (001): 0.
  - RDN (010): sign && (G || S).
  - RUP (011): !sign && (G || S).
  - RMM (100): G.
  - Codes 101–111 are treated as RNE.
- Range check on the rounded magnitude R (33 bits):
  - Signed, positive: R >= 2^31 is invalid.
  - Signed, negative: R > 2^31 is invalid.
  - Unsigned, positive: R >= 2^32 is invalid.
  - Unsigned, negative: R != 0 is invalid.
  - NaN and ±Inf are always invalid.
- Invalid results:
  - Signed: NaN or positive overflow → 0x7FFFFFFF; negative overflow → 0x80000000.
  - Unsigned: NaN or positive overflow → 0xFFFFFFFF; negative → 0x00000000.
- Valid results: int_out = sign ? −R : R (two's complement).
- Flags:
  - NV = invalid.
  - NX = (G || S) && !NV.
  - NV and NX are never both set.
  - −0.0 → 0 with no flags.
  - An unsigned negative input that rounds to 0 (e.g. −0.3 with RTZ) → 0, NX = 1, NV = 0.

## Timing
- Pipeline has two registered stages:
  - S1: decode, shift amount, right shift with sticky, special-case classification.
  - S2: rounding increment, range check, negation/saturation, flags.
- Latency: 2 cycles from in-transfer to valid_out, with no stall.
- Throughput: one conversion per cycle.
- Stall and advance rules:
  - S2 holds while valid_out && !ready_in.
  - S1 advances when S2 is empty or S2 is performing an out-transfer in the same cycle.
  - ready_out = !reset && (!S1.valid || S1 advances).
  - Bubbles collapse: an empty S2 is refilled while a full S2 stalls.
- Outputs int_out, NV and NX are registered and stay stable while valid_out && !ready_in.
- Reset values: valid_out = 0, int_out = 0, NV = 0, NX = 0, both stage valid bits = 0, ready_out = 0 while reset is high.
- Reset mid-operation: in-flight results in both stages are discarded, with no output transfer. The first in-transfer is possible in the first cycle after reset deasserts.
- Simultaneous in-transfer and out-transfer with both stages full: S1 moves to S2 and the new operand enters S1 in the same edge, with no loss.

## Structure
- Shared package fpu_pkg holds:
  - the rounding-mode enum (RNE, RTZ, RDN, RUP, RMM);
  - FP32 field constants: bias 127, exponent width 8, fraction width 23;
  - saturation constants INT32_MAX, INT32_MIN, UINT32_MAX.
- The classification helper is_nan/is_inf lives in fpu_pkg and is shared with the other FPU units.
- One sub-module, shift_right_sticky_32: a 32-bit logarithmic right shifter with a 5-bit amount. It outputs the shifted value, the guard bit, and the sticky OR of all dropped bits.

## Test plan
- 0x40200000 (2.5):
  - signed, RNE → 2, NX = 1.
  - RMM → 3.
  - RUP → 3.
  - RTZ → 2.
- 0xCF000000 (−2^31), signed, RTZ → 0x80000000, no flags. 0x4F000000 (+2^31), signed → 0x7FFFFFFF, NV = 1.
- 0xBE99999A (−0.3):
  - unsigned, RTZ → 0, NX = 1, NV = 0.
  - unsigned, RDN → 0, NV = 1, NX = 0.
  - signed, RDN → 0xFFFFFFFF, NX = 1.
- 0x7FC00000 (qNaN): signed → 0x7FFFFFFF, unsigned → 0xFFFFFFFF, NV = 1 in both. 0x80000000 (−0.0) → 0, no flags. 0x00000001 (subnormal) → 0, NX = 1.
- Back-to-back stream of 8 operands with ready_in held low for 3 cycles mid-stream:
  - all 8 results arrive in order, with none dropped or duplicated;
  - ready_out drops only while both stages are full.
- Reset asserted for one cycle while both stages are valid:
  - valid_out = 0 on the next cycle;
  - ready_out = 0 during reset and 1 on the first cycle after reset deasserts;
  - no stale result is emitted afterwards.
